ssp_rx_receive: RTL

Receive half of the SSP: oversamples the serial receive pins on `pclk`, deserializes frame-synchronised 8-bit words MSB-first, and buffers them in a 4-entry receive FIFO read by the APB side. It is the receive-side counterpart of the transmit FIFO and transmit logic. It sits between the SSP pins (`sspclkin`, `sspfssin`, `ssprxd`) and the APB register interface, and raises `ssprxintr` when the buffer is full.

---
 rtl/ssp_rx_receive.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ssp_rx_receive.sv
// SSP receive path: oversampled pin capture, frame-synced MSB-first deserializer, 4x8 receive FIFO.
// Optional sticky overrun flag on sspoeintr when SSP_RX_OVERRUN_EN is defined.
module ssp_rx_receive (
  input  logic       pclk,
  input  logic       clear_b,
  input  logic       psel,
  input  logic       pwrite,
  output logic [7:0] prdata,
  input  logic       sspclkin,
  input  logic       sspfssin,
  input  logic       ssprxd,
`ifdef SSP_RX_OVERRUN_EN
  output logic       sspoeintr,
`endif
  output logic       ssprxintr
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic       r_clk_q;
  logic       r_clk_qq;
  logic       r_fss_q;
  logic       r_rxd_q;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_bitcnt;
  logic [2:0] w_bitcnt_nxt;
  logic [7:0] r_shreg;
  logic [7:0] w_shreg_nxt;
  logic       w_evt;
  logic       w_push;
  logic [7:0] r_mem [4];
  logic [1:0] r_rptr;
  logic [1:0] r_wptr;
  logic [2:0] r_count;
  logic       w_rd_req;
  logic       w_rd;
  logic       w_full;
  logic       w_push_ok;

  // clk_qq lags clk_q by one pclk so a rising sspclkin shows up as a one-cycle event.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_clk_q  <= 1'b0;
      r_clk_qq <= 1'b0;
      r_fss_q  <= 1'b0;
      r_rxd_q  <= 1'b0;
    end else begin
      r_clk_q  <= sspclkin;
      r_clk_qq <= r_clk_q;
      r_fss_q  <= sspfssin;
      r_rxd_q  <= ssprxd;
    end
  end

  assign w_evt = r_clk_q & ~r_clk_qq;

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shreg_nxt  = r_shreg;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_evt && r_fss_q) begin
          w_state_nxt  = RECV;
          w_bitcnt_nxt = 3'd0;
        end
      end
      RECV: begin
        if (w_evt) begin
          w_shreg_nxt  = {r_shreg[6:0], r_rxd_q};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          // The 8th bit completes the word; fss seen on it starts the next frame directly.
          if (r_bitcnt == 3'd7) begin
            w_push       = 1'b1;
            w_bitcnt_nxt = 3'd0;
            w_state_nxt  = r_fss_q ? RECV : IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_state  <= IDLE;
      r_bitcnt <= 3'd0;
      r_shreg  <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shreg  <= w_shreg_nxt;
    end
  end

  assign w_full   = (r_count == 3'd4);
  assign w_rd_req = psel & ~pwrite;
  assign w_rd     = w_rd_req & (r_count != 3'd0);
  // A read from full frees the slot the same edge, so the push still lands.
  assign w_push_ok = w_push & (~w_full | w_rd);

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
      r_rptr  <= 2'd0;
      r_wptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= w_shreg_nxt;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_rd) r_rptr <= r_rptr + 2'd1;
      case ({w_push_ok, w_rd})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign prdata    = (r_count != 3'd0) ? r_mem[r_rptr] : 8'h00;
  assign ssprxintr = w_full;

`ifdef SSP_RX_OVERRUN_EN
  logic r_oe;

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_oe <= 1'b0;
    end else if (w_rd_req) begin
      r_oe <= 1'b0;
    end else if (w_push && w_full) begin
      r_oe <= 1'b1;
    end
  end

  assign sspoeintr = r_oe;
`endif

endmodule
